drive_sequencer: RTL and testbench

- Sequences the drive-motor PWM channel and shares it between two command sources.
  - Host: manual commands from the UART path.
  - Auto: steering/throttle commands from the camera/JPEG path.
- Arbitrates the sources, clamps the commanded pulse width and ramps the applied width once per PWM frame.
- Generates the 50 Hz servo/ESC waveform on `power`.
- A frame-based watchdog forces neutral when commands stop.

---
 rtl/drive_pkg.sv | 29 ++
 rtl/pwm_frame_gen.sv | 41 ++++
 rtl/drive_sequencer.sv | 127 ++++++++++++
 tb/tb_drive_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared constants, state encoding and pulse-width clamp for the drive-motor PWM path.
package drive_pkg;

    localparam int PW_W = 17;

    localparam int FRAME_CYCLES_DEF = 1000000;
    localparam int PW_NEUTRAL_DEF   = 75260;
    localparam int PW_MIN_DEF       = 70260;
    localparam int PW_MAX_DEF       = 80260;
    localparam int STEP_DEF         = 500;
    localparam int WDOG_FRAMES_DEF  = 25;
    localparam int HOLD_FRAMES_DEF  = 50;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOST     = 2'd1,
        AUTO     = 2'd2,
        FAILSAFE = 2'd3
    } drive_state_e;

    function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] pw,
                                                 input logic [PW_W-1:0] lo,
                                                 input logic [PW_W-1:0] hi);
        if (pw < lo)      return lo;
        else if (pw > hi) return hi;
        else              return pw;
    endfunction

endpackage

// File: rtl/pwm_frame_gen.sv
// Frame counter and registered PWM compare; exports frame_start and the end-of-frame boundary strobe.
module pwm_frame_gen
    import drive_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic            m_clock,
    input  logic            p_reset,
    input  logic [PW_W-1:0] cur_pw,
    output logic            power,
    output logic            frame_start,
    output logic            boundary
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             power_q, power_d;

    assign boundary    = (cnt_q == LAST);
    assign frame_start = (cnt_q == '0);
    assign power       = power_q;

    always_comb begin
        cnt_d   = boundary ? '0 : cnt_q + CNT_W'(1);
        power_d = (32'(cnt_q) < 32'(cur_pw));
    end

    // Reset drops power at once, truncating any pulse in flight.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            cnt_q   <= '0;
            power_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            power_q <= power_d;
        end
    end

endmodule

// File: rtl/drive_sequencer.sv
// Drive PWM sequencer: host/auto arbitration, clamp, per-frame ramp and watchdog failsafe.
// Build option DRIVE_SEQ_RAMP_EN: defined = rate-limited ramp, undefined = step to target at each boundary.
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter int PW_NEUTRAL   = PW_NEUTRAL_DEF,
    parameter int PW_MIN       = PW_MIN_DEF,
    parameter int PW_MAX       = PW_MAX_DEF,
    parameter int STEP         = STEP_DEF,
    parameter int WDOG_FRAMES  = WDOG_FRAMES_DEF,
    parameter int HOLD_FRAMES  = HOLD_FRAMES_DEF
) (
    input  logic            m_clock,
    input  logic            p_reset,
    input  logic            host_valid,
    output logic            host_ready,
    input  logic [PW_W-1:0] host_pw,
    input  logic            auto_valid,
    output logic            auto_ready,
    input  logic [PW_W-1:0] auto_pw,
    output logic            power,
    output logic [PW_W-1:0] cur_pw,
    output logic [1:0]      src,
    output logic            wdog_trip,
    output logic            frame_start
);

    localparam int WD_W   = $clog2(WDOG_FRAMES + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [PW_W-1:0]   NEUTRAL = PW_W'(PW_NEUTRAL);
    localparam logic [PW_W-1:0]   LO      = PW_W'(PW_MIN);
    localparam logic [PW_W-1:0]   HI      = PW_W'(PW_MAX);
    localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(WDOG_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_FRAMES);

    drive_state_e      state_q, state_d;
    logic [PW_W-1:0]   target_q, target_d;
    logic [PW_W-1:0]   cur_pw_q, cur_pw_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic            boundary;
    logic            host_acc, auto_acc, acc, trip;
    logic [PW_W-1:0] ramp_pw;
`ifdef DRIVE_SEQ_RAMP_EN
    logic [PW_W:0]   up_pw, dn_gap;
`endif

    assign host_ready = ~p_reset;
    assign auto_ready = ~host_valid & (hold_q == '0);
    assign host_acc   = host_valid & host_ready;
    assign auto_acc   = auto_valid & auto_ready;
    assign acc        = host_acc | auto_acc;

    assign cur_pw    = cur_pw_q;
    assign src       = state_q;
    assign wdog_trip = (state_q == FAILSAFE);

    pwm_frame_gen #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_frame (
        .m_clock    (m_clock),
        .p_reset    (p_reset),
        .cur_pw     (cur_pw_q),
        .power      (power),
        .frame_start(frame_start),
        .boundary   (boundary)
    );

    always_comb begin
        ramp_pw = cur_pw_q;
`ifdef DRIVE_SEQ_RAMP_EN
        up_pw  = {1'b0, cur_pw_q} + (PW_W+1)'(STEP);
        dn_gap = {1'b0, cur_pw_q} - {1'b0, target_q};
        if (cur_pw_q < target_q)
            ramp_pw = (up_pw > {1'b0, target_q}) ? target_q : up_pw[PW_W-1:0];
        else if (cur_pw_q > target_q)
            ramp_pw = (dn_gap > (PW_W+1)'(STEP)) ? cur_pw_q - PW_W'(STEP) : target_q;
`else
        ramp_pw = target_q;
`endif
        // Ramp reads target_q, so an accept on the boundary cycle lands one frame later.
        cur_pw_d = boundary ? ramp_pw : cur_pw_q;

        hold_d = hold_q;
        if (host_acc)                        hold_d = HOLD_LD;
        else if (boundary && hold_q != '0)   hold_d = hold_q - HOLD_W'(1);

        wdog_d = wdog_q;
        if (acc)                             wdog_d = '0;
        else if (boundary && wdog_q != WD_MAX) wdog_d = wdog_q + WD_W'(1);

        // IDLE never trips; an accept on the same edge wins.
        trip = !acc && (wdog_d == WD_MAX) && (state_q == HOST || state_q == AUTO);

        state_d  = state_q;
        target_d = target_q;
        if (host_acc) begin
            state_d  = HOST;
            target_d = clamp_pw(host_pw, LO, HI);
        end else if (auto_acc) begin
            state_d  = AUTO;
            target_d = clamp_pw(auto_pw, LO, HI);
        end else if (trip) begin
            state_d  = FAILSAFE;
            target_d = NEUTRAL;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q  <= IDLE;
            target_q <= NEUTRAL;
            cur_pw_q <= NEUTRAL;
            wdog_q   <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cur_pw_q <= cur_pw_d;
            wdog_q   <= wdog_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// Scoreboard bench for drive_sequencer using a scaled-down frame so many frames fit in a short run.
module tb_drive_sequencer;
    import drive_pkg::*;

    localparam int FC   = 64;
    localparam int NEU  = 30;
    localparam int PMIN = 20;
    localparam int PMAX = 40;
    localparam int STP  = 3;
    localparam int WD   = 5;
    localparam int HLD  = 4;

    logic            m_clock = 1'b0;
    logic            p_reset = 1'b1;
    logic            host_valid = 1'b0, auto_valid = 1'b0;
    logic [PW_W-1:0] host_pw = '0, auto_pw = '0;
    logic            host_ready, auto_ready, power, wdog_trip, frame_start;
    logic [PW_W-1:0] cur_pw;
    logic [1:0]      src;

    drive_sequencer #(
        .FRAME_CYCLES(FC), .PW_NEUTRAL(NEU), .PW_MIN(PMIN), .PW_MAX(PMAX),
        .STEP(STP), .WDOG_FRAMES(WD), .HOLD_FRAMES(HLD)
    ) dut (
        .m_clock(m_clock), .p_reset(p_reset),
        .host_valid(host_valid), .host_ready(host_ready), .host_pw(host_pw),
        .auto_valid(auto_valid), .auto_ready(auto_ready), .auto_pw(auto_pw),
        .power(power), .cur_pw(cur_pw), .src(src), .wdog_trip(wdog_trip),
        .frame_start(frame_start)
    );

    always #5 m_clock = ~m_clock;

    typedef struct { int cur; int src; int trip; int width; bit chk_w; } frame_t;
    typedef struct { int hr; int ar; } rdy_t;
    typedef struct { int power; int cur; int src; int trip; int fs; int hr; } snap_t;

    frame_t fq[$];
    rdy_t   rq[$];
    snap_t  sq[$];
    int     checks = 0, failures = 0;
    int     hi_cnt = 0;
    bit     snap_req = 1'b0;

    int m_cur, m_tgt, m_wd, m_hold, m_src;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic queue_empty_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: DUT event with no expected entry at %0t", name, $time);
    endtask

    function automatic int clampm(input int v);
        return (v < PMIN) ? PMIN : (v > PMAX) ? PMAX : v;
    endfunction

    function automatic int rampm(input int c, input int t);
`ifdef DRIVE_SEQ_RAMP_EN
        if (t - c > STP) return c + STP;
        if (c - t > STP) return c - STP;
        return t;
`else
        return t;
`endif
    endfunction

    task automatic model_reset();
        m_cur = NEU; m_tgt = NEU; m_wd = 0; m_hold = 0; m_src = 0;
    endtask

    // One full frame: optional one-cycle command at count 10, then run to the next frame start.
    task automatic frame(input bit hv, input int hpw, input bit av, input int apw);
        int last;
        repeat (10) @(posedge m_clock);
        #1;
        if (hv || av) begin
            host_valid = hv; host_pw = PW_W'(hpw);
            auto_valid = av; auto_pw = PW_W'(apw);
            rq.push_back('{1, (!hv && m_hold == 0) ? 1 : 0});
            if (hv) begin
                m_tgt = clampm(hpw); m_src = 1; m_wd = 0; m_hold = HLD;
            end else if (m_hold == 0) begin
                m_tgt = clampm(apw); m_src = 2; m_wd = 0;
            end
        end
        @(posedge m_clock);
        #1;
        host_valid = 1'b0; auto_valid = 1'b0;
        last   = m_cur;
        m_cur  = rampm(m_cur, m_tgt);
        if (m_hold > 0) m_hold--;
        if (m_wd < WD)  m_wd++;
        if (m_wd == WD && (m_src == 1 || m_src == 2)) begin
            m_tgt = NEU; m_src = 3;
        end
        fq.push_back('{m_cur, m_src, (m_src == 3) ? 1 : 0, last, 1'b1});
        repeat (FC - 11) @(posedge m_clock);
        #1;
    endtask

    task automatic snap(input int pw_o, input int cur, input int s, input int tr, input int fs, input int hr);
        sq.push_back('{pw_o, cur, s, tr, fs, hr});
        snap_req = 1'b1;
        @(posedge m_clock);
        #1;
        snap_req = 1'b0;
    endtask

    always @(negedge m_clock) begin
        if (snap_req) begin
            if (sq.size() == 0) queue_empty_fail("snap_q");
            else begin
                snap_t s;
                s = sq.pop_front();
                check("snap_power", 32'(power), s.power);
                check("snap_cur_pw", 32'(cur_pw), s.cur);
                check("snap_src", 32'(src), s.src);
                check("snap_wdog_trip", 32'(wdog_trip), s.trip);
                check("snap_frame_start", 32'(frame_start), s.fs);
                check("snap_host_ready", 32'(host_ready), s.hr);
            end
        end
        if (p_reset) hi_cnt = 0;
        else begin
            if (host_valid || auto_valid) begin
                if (rq.size() == 0) queue_empty_fail("ready_q");
                else begin
                    rdy_t r;
                    r = rq.pop_front();
                    check("host_ready", 32'(host_ready), r.hr);
                    check("auto_ready", 32'(auto_ready), r.ar);
                end
            end
            if (frame_start) begin
                if (fq.size() == 0) queue_empty_fail("frame_q");
                else begin
                    frame_t f;
                    f = fq.pop_front();
                    check("frame_cur_pw", 32'(cur_pw), f.cur);
                    check("frame_src", 32'(src), f.src);
                    check("frame_wdog_trip", 32'(wdog_trip), f.trip);
                    if (f.chk_w) check("pulse_width", hi_cnt, f.width);
                end
                hi_cnt = 0;
            end else begin
                hi_cnt += int'(power);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge m_clock);
        #1;
        snap(0, NEU, 0, 0, 1, 0);
        fq.push_back('{NEU, 0, 0, 0, 1'b0});
        p_reset = 1'b0;

        // Silence from IDLE never trips.
        repeat (7) frame(0, 0, 0, 0);

        frame(1, 40, 0, 0);
        repeat (3) frame(0, 0, 0, 0);

        // Clamped host command, then auto offered through the hold window.
        frame(1, 90000, 0, 0);
        repeat (4) frame(0, 0, 1, 20);
        repeat (2) frame(0, 0, 0, 0);

        // Simultaneous offer: host wins, auto stalled.
        frame(1, 35, 1, 25);
        repeat (4) frame(0, 0, 1, 37);

        // Silence under AUTO trips to failsafe and ramps back to neutral.
        repeat (8) frame(0, 0, 0, 0);

        frame(1, 40, 0, 0);
        repeat (3) frame(0, 0, 0, 0);

        // Reset in the middle of a full-width pulse.
        repeat (5) @(posedge m_clock);
        #1;
        snap(1, 40, 1, 0, 0, 1);
        p_reset = 1'b1;
        @(posedge m_clock);
        #1;
        snap(0, NEU, 0, 0, 1, 0);
        model_reset();
        fq.push_back('{NEU, 0, 0, 0, 1'b0});
        p_reset = 1'b0;
        repeat (2) frame(0, 0, 0, 0);

        repeat (3) @(posedge m_clock);
        #1;
        check("frame_q_drained", fq.size(), 0);
        check("ready_q_drained", rq.size(), 0);
        check("snap_q_drained", sq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
